// File: rtl/thermocouple_pkg.sv
// ============================================================================
// thermocouple_pkg : shared types and frame layout for thermocouple readers
// Rev 1.0
// ============================================================================
`default_nettype none

package thermocouple_pkg;

  localparam int TC_W  = 14;
  localparam int JT_W  = 12;
  localparam int FLT_W = 4;

  localparam int FRAME_TC_MSB = 31;
  localparam int FRAME_TC_LSB = 18;
  localparam int FRAME_FAULT  = 16;
  localparam int FRAME_JT_MSB = 15;
  localparam int FRAME_JT_LSB = 4;
  localparam int FRAME_SCV    = 2;
  localparam int FRAME_OC     = 0;

  typedef enum logic [2:0] {
    POWERUP   = 3'd0,
    SELECT    = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    UPDATE    = 3'd5,
    GAP       = 3'd6
  } state_t;

  typedef struct packed {
    logic [TC_W-1:0]  tc;
    logic [JT_W-1:0]  jt;
    logic [FLT_W-1:0] flt;
  } tc_sample_t;

endpackage

`default_nettype wire

// File: rtl/tc_frame_decode.sv
// ============================================================================
// tc_frame_decode : splits a 32-bit MAX31855-style frame into its raw fields
// Rev 1.0
// ============================================================================
`default_nettype none

module tc_frame_decode
  import thermocouple_pkg::*;
(
  input  logic [31:0] frame,
  output tc_sample_t  sample
);

  always_comb begin
    sample     = '0;
    sample.tc  = frame[FRAME_TC_MSB:FRAME_TC_LSB];
    sample.jt  = frame[FRAME_JT_MSB:FRAME_JT_LSB];
    // Summary fault flag sits on top so consumers can test a single bit.
    sample.flt = {frame[FRAME_FAULT], frame[FRAME_SCV:FRAME_OC]};
  end

endmodule

`default_nettype wire

// File: rtl/thermocouple_scanner.sv
// ============================================================================
// thermocouple_scanner : round-robin poller of NUM_CH thermocouple sensors
// Rev 1.0
// ============================================================================
`default_nettype none

module thermocouple_scanner
  import thermocouple_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int POWERUP_CYCLES = 30,
  parameter  int GAP_CYCLES     = 10,
  parameter  int TIMEOUT_CYCLES = 64,
  parameter  int HOLD_ON_FAULT  = 1,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    spi_busy,
  input  logic [31:0]             spi_rx_data,
  output logic                    spi_start,
  output logic [CH_W-1:0]         spi_cs_sel,
  output logic [NUM_CH*TC_W-1:0]  tc_temp,
  output logic [NUM_CH*JT_W-1:0]  junction_temp,
  output logic [NUM_CH*FLT_W-1:0] fault_bits,
  output logic [NUM_CH-1:0]       timeout_flag,
  output logic                    sample_valid,
  output logic [CH_W-1:0]         sample_ch
);

  localparam int CNT_PG  = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (CNT_PG > TIMEOUT_CYCLES) ? CNT_PG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [CH_W-1:0]  r_cs, w_next_ch, r_sample_ch;
  logic             r_first, w_found;
  logic             r_sample_valid;
  logic             w_sel_load, w_capture, w_timeout, w_update, w_hold;
  logic [31:0]      r_frame;
  tc_sample_t       w_sample;

  assign w_cnt_inc = r_cnt + 1'b1;

  // First enabled channel after the current one; the first pass after reset starts at 0.
  always_comb begin : next_ch_search
    int base;
    int idx;
    w_found   = 1'b0;
    w_next_ch = r_cs;
    base      = r_first ? 0 : ((int'(r_cs) >= NUM_CH - 1) ? 0 : int'(r_cs) + 1);
    idx       = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (ch_en[idx]) begin
        w_found   = 1'b1;
        w_next_ch = CH_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    spi_start    = 1'b0;
    w_sel_load   = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      POWERUP: begin
        if (w_cnt_inc == CNT_W'(POWERUP_CYCLES)) begin
          w_state_next = SELECT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      SELECT: begin
        if (w_found) begin
          w_sel_load   = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (!spi_busy) begin
          spi_start    = 1'b1;
          w_state_next = WAIT_BUSY;
          w_cnt_next   = '0;
        end
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          w_state_next = WAIT_DONE;
          w_cnt_next   = '0;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) begin
          w_capture    = 1'b1;
          w_state_next = UPDATE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      UPDATE: begin
        w_state_next = GAP;
        w_cnt_next   = '0;
      end
      GAP: begin
        if (w_cnt_inc == CNT_W'(GAP_CYCLES)) begin
          w_state_next = SELECT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = SELECT;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= POWERUP;
      r_cnt          <= '0;
      r_cs           <= '0;
      r_first        <= 1'b1;
      r_frame        <= '0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_sample_valid <= w_update;
      if (w_sel_load) begin
        r_cs    <= w_next_ch;
        r_first <= 1'b0;
      end
      if (w_capture) r_frame <= spi_rx_data;
      if (w_update) r_sample_ch <= r_cs;
    end
  end

  tc_frame_decode u_decode (
    .frame  (r_frame),
    .sample (w_sample)
  );

  assign w_update = (r_state == UPDATE);
  assign w_hold   = (HOLD_ON_FAULT != 0) && w_sample.flt[FLT_W-1];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [TC_W-1:0]  r_tc;
    logic [JT_W-1:0]  r_jt;
    logic [FLT_W-1:0] r_flt;
    logic             r_to;
    logic             w_hit;

    assign w_hit = (r_cs == CH_W'(k));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_tc  <= '0;
        r_jt  <= '0;
        r_flt <= '0;
        r_to  <= 1'b0;
      end else if (w_update && w_hit) begin
        r_flt <= w_sample.flt;
        r_to  <= 1'b0;
        if (!w_hold) begin
          r_tc <= w_sample.tc;
          r_jt <= w_sample.jt;
        end
      end else if (w_timeout && w_hit) begin
        r_to <= 1'b1;
      end
    end

    assign tc_temp[k*TC_W +: TC_W]        = r_tc;
    assign junction_temp[k*JT_W +: JT_W]  = r_jt;
    assign fault_bits[k*FLT_W +: FLT_W]   = r_flt;
    assign timeout_flag[k]                = r_to;
  end

  assign spi_cs_sel   = r_cs;
  assign sample_valid = r_sample_valid;
  assign sample_ch    = r_sample_ch;

endmodule

`default_nettype wire

// File: tb/tb_thermocouple_scanner.sv
// ============================================================================
// tb_thermocouple_scanner : directed bench with a behavioural SPI master model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_thermocouple_scanner;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_CH-1:0]     ch_en = '0;
  logic                  spi_busy = 1'b0;
  logic [31:0]           spi_rx_data = '0;
  logic                  spi_start;
  logic [CH_W-1:0]       spi_cs_sel;
  logic [NUM_CH*14-1:0]  tc_temp;
  logic [NUM_CH*12-1:0]  junction_temp;
  logic [NUM_CH*4-1:0]   fault_bits;
  logic [NUM_CH-1:0]     timeout_flag;
  logic                  sample_valid;
  logic [CH_W-1:0]       sample_ch;

  always #5 clk = ~clk;

  thermocouple_scanner #(
    .NUM_CH(4), .POWERUP_CYCLES(30), .GAP_CYCLES(10), .TIMEOUT_CYCLES(64), .HOLD_ON_FAULT(1)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .spi_busy(spi_busy), .spi_rx_data(spi_rx_data),
    .spi_start(spi_start), .spi_cs_sel(spi_cs_sel), .tc_temp(tc_temp),
    .junction_temp(junction_temp), .fault_bits(fault_bits), .timeout_flag(timeout_flag),
    .sample_valid(sample_valid), .sample_ch(sample_ch)
  );

  typedef struct {
    int          ch;
    logic [31:0] frame;
    logic [13:0] tc;
    logic [11:0] jt;
    logic [3:0]  flt;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] frames [NUM_CH];
  bit          dead_en = 1'b0;
  int          dead_ch = 3;
  int          start_cnt = 0;
  int          start_log [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [13:0] tc_of(input int c);
    return tc_temp[c*14 +: 14];
  endfunction
  function automatic logic [11:0] jt_of(input int c);
    return junction_temp[c*12 +: 12];
  endfunction
  function automatic logic [3:0] flt_of(input int c);
    return fault_bits[c*4 +: 4];
  endfunction

  // SPI master model: busy rises the clock after spi_start and stays high 8 clocks.
  initial begin : spi_model
    int cur;
    forever begin
      @(negedge clk);
      if (spi_start && !rst) begin
        start_cnt++;
        cur = int'(spi_cs_sel);
        start_log.push_back(cur);
        if (!(dead_en && cur == dead_ch)) begin
          @(negedge clk);
          spi_busy    = 1'b1;
          spi_rx_data = 32'hDEAD_BEEF;
          repeat (7) @(negedge clk);
          spi_rx_data = frames[cur];
          @(negedge clk);
          spi_busy    = 1'b0;
        end
      end
    end
  end

  task automatic wait_sample(input int budget, output bit ok, output int ch);
    int n;
    n  = 0;
    ok = 1'b0;
    ch = -1;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (sample_valid) begin
        ok = 1'b1;
        ch = int'(sample_ch);
      end
    end
  endtask

  task automatic wait_sample_on(input int want, output bit ok);
    bit got;
    int c;
    int tries;
    tries = 0;
    ok    = 1'b0;
    while (!ok && tries < 8) begin
      wait_sample(300, got, c);
      tries++;
      if (got && c == want) ok = 1'b1;
    end
  endtask

  // Releases rst at a falling edge and counts rising edges until spi_start appears.
  task automatic release_and_time(input string tag);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    rst  = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (spi_start) seen = 1'b1;
    end
    check({tag, "_first_start_delay"}, k, 31);
    check({tag, "_first_cs"}, spi_cs_sel, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tc"}, tc_temp, 0);
    check({tag, "_jt"}, junction_temp, 0);
    check({tag, "_flt"}, fault_bits, 0);
    check({tag, "_timeout"}, timeout_flag, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_sample_ch"}, sample_ch, 0);
    check({tag, "_start"}, spi_start, 0);
    check({tag, "_cs"}, spi_cs_sel, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs [5];
    int   exp_seq [4];
    bit   ok;
    int   c;
    int   d;
    int   s0;
    bit   bad;

    vecs[0] = '{0, 32'h0640_0320, 14'h0190, 12'h032, 4'h0};
    vecs[1] = '{1, 32'h7FFC_FFF0, 14'h1FFF, 12'hFFF, 4'h0};
    vecs[2] = '{2, 32'h1900_1900, 14'h0640, 12'h190, 4'h0};
    vecs[3] = '{3, 32'hFFFC_0007, 14'h3FFF, 12'h000, 4'h7};
    vecs[4] = '{0, 32'h0004_0010, 14'h0001, 12'h001, 4'h0};
    exp_seq = '{2, 0, 2, 0};

    for (int i = 0; i < NUM_CH; i++) frames[i] = vecs[i].frame;
    ch_en = 4'b1111;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    release_and_time("boot");

    // Full scan 0,1,2,3,0 with per-channel field checks.
    for (int i = 0; i < 5; i++) begin
      frames[vecs[i].ch] = vecs[i].frame;
      wait_sample(200, ok, c);
      check("scan_sample_seen", ok, 1);
      check("scan_sample_ch", c, vecs[i].ch);
      check("scan_tc", tc_of(vecs[i].ch), vecs[i].tc);
      check("scan_jt", jt_of(vecs[i].ch), vecs[i].jt);
      check("scan_flt", flt_of(vecs[i].ch), vecs[i].flt);
      @(negedge clk);
      check("scan_valid_one_cycle", sample_valid, 0);
    end
    check("scan_no_timeout", timeout_flag, 0);

    // Faulted frame on ch1 must keep the previous good temperatures.
    frames[1] = 32'hFFFF_0001;
    wait_sample_on(1, ok);
    check("hold_seen", ok, 1);
    check("hold_flt", flt_of(1), 4'b1001);
    check("hold_tc", tc_of(1), 14'h1FFF);
    check("hold_jt", jt_of(1), 12'hFFF);
    frames[1] = 32'h7FFC_FFF0;

    // Sparse mask: only channels 0 and 2.
    ch_en = 4'b0101;
    start_log.delete();
    for (int j = 0; j < 4; j++) begin
      wait_sample(200, ok, c);
      check("mask_sample_ch", c, exp_seq[j]);
    end
    check("mask_start_count", start_log.size(), 4);
    for (int j = 0; j < 4 && j < start_log.size(); j++)
      check("mask_start_cs", start_log[j], exp_seq[j]);

    // Empty mask: the scanner idles without starting a transfer.
    ch_en = 4'b0000;
    s0    = start_cnt;
    wait_sample(300, ok, c);
    check("idle_no_sample", ok, 0);
    check("idle_no_start", start_cnt - s0, 0);
    check("idle_cs_held", spi_cs_sel, 0);

    // Channel 3 never answers: timeout flag, no sample, scan resumes at 0.
    dead_en = 1'b1;
    ch_en   = 4'b1111;
    ok      = 1'b0;
    d       = 0;
    while (!ok && d < 500) begin
      @(negedge clk);
      d++;
      if (spi_start && spi_cs_sel == 2'd3) ok = 1'b1;
    end
    check("to_ch3_started", ok, 1);
    d   = 0;
    bad = 1'b0;
    while (!timeout_flag[3] && d < 200) begin
      @(negedge clk);
      d++;
      if (sample_valid) bad = 1'b1;
    end
    // One clock of slack on where the 64-clock timeout window is anchored.
    check("to_delay_in_range", (d >= 64 && d <= 66), 1);
    check("to_no_sample", bad, 0);
    wait_sample(200, ok, c);
    check("to_resume_ch", c, 0);
    check("to_flag_sticky", timeout_flag, 4'b1000);

    dead_en   = 1'b0;
    frames[3] = 32'h0C80_0A50;
    wait_sample_on(3, ok);
    check("to_recover_seen", ok, 1);
    check("to_flag_cleared", timeout_flag[3], 0);
    check("to_recover_tc", tc_of(3), 14'h0320);
    check("to_recover_jt", jt_of(3), 12'h0A5);

    // Reset while a transfer is in WAIT_DONE.
    ok = 1'b0;
    d  = 0;
    while (!ok && d < 300) begin
      @(negedge clk);
      d++;
      if (spi_busy) ok = 1'b1;
    end
    check("midrst_busy_seen", ok, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    release_and_time("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
